// File: rtl/rst_request_pkg.sv
// -----------------------------------------------------------------------------
// rst_request_pkg
// Shared definitions for the reset-request block: FSM state encoding, request
// cause codes, counter width, real/simulation timer constants and small
// helper functions used to pick timer limits and step counters.
// -----------------------------------------------------------------------------
package rst_request_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_ASSERT     = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_BUTTON   = 2'b01,
        CAUSE_WATCHDOG = 2'b10
    } cause_t;

    localparam int CNT_W = 16;

    // Timer lengths in clk cycles: hardware values and shortened values
    // for simulation.
    localparam int unsigned DEBOUNCE_REAL = 10000;
    localparam int unsigned DEBOUNCE_SIM  = 4;
    localparam int unsigned PULSE_REAL    = 1000;
    localparam int unsigned PULSE_SIM     = 3;
    localparam int unsigned WDT_REAL      = 50000;
    localparam int unsigned WDT_SIM       = 20;

    function automatic int unsigned timer_sel(input bit sim,
                                              input int unsigned sim_cycles,
                                              input int unsigned real_cycles);
        return sim ? sim_cycles : real_cycles;
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rst_request_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset, both flops clear to 0
//   d        - asynchronous input
//   q        - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/rst_request.sv
// -----------------------------------------------------------------------------
// rst_request
// Generates an active-low reset request from a debounced push-button or from
// a watchdog timeout. A button press must be stable for the debounce window
// before a pulse is issued, and the button must then be released (and stay
// released for a debounce window) before another press is accepted, so a
// held button yields a single request.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   btn_in     - raw asynchronous push-button, active-high
//   wdt_en     - watchdog enable (synchronous)
//   wdt_kick   - single-cycle watchdog service strobe
//   rst_req_n  - registered active-low reset request
//   cause      - source of the last request (00 none, 01 button, 10 watchdog)
//   busy       - high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module rst_request
    import rst_request_pkg::*;
#(
    parameter bit SIMULATION = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       rst_req_n,
    output logic [1:0] cause,
    output logic       busy
);

    localparam int unsigned DEBOUNCE_MS  = timer_sel(SIMULATION, DEBOUNCE_SIM, DEBOUNCE_REAL);
    localparam int unsigned PULSE_CYCLES = timer_sel(SIMULATION, PULSE_SIM, PULSE_REAL);
    localparam int unsigned WDT_CYCLES   = timer_sel(SIMULATION, WDT_SIM, WDT_REAL);

    // Counters are compared for equality against the last count value.
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(WDT_CYCLES - 1);

    logic             btn_sync;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] tmr_reg, tmr_next;   // debounce / pulse-width timer
    logic [CNT_W-1:0] wdt_reg, wdt_next;
    cause_t           cause_reg, cause_next;
    logic             rst_req_n_reg, rst_req_n_next;
    logic             wdt_expire;

    sync_2ff u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // State register and all timing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            tmr_reg       <= '0;
            wdt_reg       <= '0;
            cause_reg     <= CAUSE_NONE;
            rst_req_n_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            tmr_reg       <= tmr_next;
            wdt_reg       <= wdt_next;
            cause_reg     <= cause_next;
            rst_req_n_reg <= rst_req_n_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        cause_next = cause_reg;

        // A kick on the expiry cycle suppresses the timeout.
        wdt_expire = (state_reg == ST_IDLE) && wdt_en && !wdt_kick && (wdt_reg == WDT_LAST);

        case (state_reg)
            ST_IDLE: begin
                // Watchdog takes priority over a simultaneous button press.
                if (wdt_expire) begin
                    state_next = ST_ASSERT;
                    tmr_next   = '0;
                    cause_next = CAUSE_WATCHDOG;
                end else if (btn_sync) begin
                    state_next = ST_PRESS_DB;
                    tmr_next   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!btn_sync) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end else if (tmr_reg == DB_LAST) begin
                    state_next = ST_ASSERT;
                    tmr_next   = '0;
                    cause_next = CAUSE_BUTTON;
                end else begin
                    tmr_next = sat_inc(tmr_reg);
                end
            end
            ST_ASSERT: begin
                if (tmr_reg == PULSE_LAST) begin
                    tmr_next   = '0;
                    state_next = (cause_reg == CAUSE_BUTTON) ? ST_RELEASE_DB : ST_IDLE;
                end else begin
                    tmr_next = sat_inc(tmr_reg);
                end
            end
            ST_RELEASE_DB: begin
                // Any high sample restarts the release window.
                if (btn_sync) begin
                    tmr_next = '0;
                end else if (tmr_reg == DB_LAST) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = sat_inc(tmr_reg);
                end
            end
            default: begin
                state_next = ST_IDLE;
                tmr_next   = '0;
            end
        endcase

        // Watchdog only runs while idle and enabled.
        if ((state_reg != ST_IDLE) || !wdt_en || wdt_kick || wdt_expire) begin
            wdt_next = '0;
        end else begin
            wdt_next = sat_inc(wdt_reg);
        end
    end

    // Outputs. The request is registered from the next state so it changes on
    // the same edge as the state and never glitches.
    always_comb begin
        rst_req_n_next = (state_next != ST_ASSERT);
        busy           = (state_reg != ST_IDLE);
    end

    assign rst_req_n = rst_req_n_reg;
    assign cause     = cause_reg;

endmodule

// File: tb/tb_rst_request.sv
// -----------------------------------------------------------------------------
// tb_rst_request
// Directed bench for rst_request with shortened timers. Expected values are
// queued before each clock edge and compared just after it.
// -----------------------------------------------------------------------------
module tb_rst_request;

    localparam int SEL_RN    = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_CAUSE = 2;

    typedef struct {
        string      tag;
        int         sel;
        logic [1:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_in;
    logic       wdt_en;
    logic       wdt_kick;
    logic       rst_req_n;
    logic [1:0] cause;
    logic       busy;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    rst_request #(.SIMULATION(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .rst_req_n (rst_req_n),
        .cause     (cause),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of run, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic push(input int sel, input logic [1:0] val, input string tag);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [1:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_RN:   obs = {1'b0, rst_req_n};
                SEL_BUSY: obs = {1'b0, busy};
                default:  obs = cause;
            endcase
            n_vec++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
            end
            $display("check %s: observed %0d expected %0d", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Hold the button for n cycles (n >= 10), then release it. The first edge
    // sampling btn_in=1 is tick 1; the request is low on ticks 7..9 and busy
    // drops 4 cycles after the synchronized button falls (tick n+6).
    task automatic press_hold(input int n);
        btn_in = 1'b1;
        for (int i = 1; i <= n; i++) begin
            push(SEL_RN, (i >= 7 && i <= 9) ? 2'd0 : 2'd1, $sformatf("press%0d_rn_t%0d", n, i));
            if (i == 2) push(SEL_BUSY, 2'd0, $sformatf("press%0d_busy_t2", n));
            if (i == 3) push(SEL_BUSY, 2'd1, $sformatf("press%0d_busy_t3", n));
            if (i == 7) push(SEL_CAUSE, 2'b01, $sformatf("press%0d_cause", n));
            tick();
        end
        btn_in = 1'b0;
        for (int i = n + 1; i <= n + 6; i++) begin
            push(SEL_RN, 2'd1, $sformatf("press%0d_rel_rn_t%0d", n, i));
            push(SEL_BUSY, (i < n + 6) ? 2'd1 : 2'd0, $sformatf("press%0d_rel_busy_t%0d", n, i));
            tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_in   = 1'b0;
        wdt_en   = 1'b0;
        wdt_kick = 1'b0;

        // Reset state.
        tick();
        push(SEL_RN, 2'd1, "reset_rn");
        push(SEL_BUSY, 2'd0, "reset_busy");
        push(SEL_CAUSE, 2'b00, "reset_cause");
        tick();
        rst_n = 1'b1;
        tick();

        // Clean press of 20 cycles.
        press_hold(20);

        // Watchdog expiry and button on the same edge: watchdog wins, back to IDLE.
        wdt_en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            btn_in = (i >= 18 && i <= 20);
            if (i == 21) wdt_en = 1'b0;
            push(SEL_RN, (i >= 20 && i <= 22) ? 2'd0 : 2'd1, $sformatf("simul_rn_t%0d", i));
            if (i == 20) push(SEL_CAUSE, 2'b10, "simul_cause");
            if (i >= 23) push(SEL_BUSY, 2'd0, $sformatf("simul_busy_t%0d", i));
            tick();
        end
        btn_in = 1'b0;

        // Bounce: 3 high, 1 low, five times.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                btn_in = (k < 3);
                push(SEL_RN, 2'd1, $sformatf("bounce_rn_r%0d_k%0d", r, k));
                tick();
            end
        end
        btn_in = 1'b0;
        push(SEL_BUSY, 2'd1, "bounce_busy_tail");
        tick();
        tick();
        push(SEL_BUSY, 2'd0, "bounce_idle");
        push(SEL_CAUSE, 2'b10, "bounce_cause_kept");
        tick();

        // Held button, one request only.
        press_hold(50);

        // Watchdog timeout with no kick.
        wdt_en = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            push(SEL_RN, (i >= 20 && i <= 22) ? 2'd0 : 2'd1, $sformatf("wdt_rn_t%0d", i));
            if (i == 20) push(SEL_CAUSE, 2'b10, "wdt_cause");
            if (i == 23) push(SEL_BUSY, 2'd0, "wdt_idle");
            tick();
        end
        wdt_en = 1'b0;
        tick();

        // Kick every 10 cycles: never times out.
        wdt_en = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            wdt_kick = (i % 10 == 0);
            push(SEL_RN, 2'd1, $sformatf("kick10_rn_t%0d", i));
            tick();
        end
        wdt_kick = 1'b0;
        wdt_en   = 1'b0;
        tick();

        // Kick on the expiry cycle; counter restarts from zero.
        wdt_en = 1'b1;
        for (int i = 1; i <= 39; i++) begin
            wdt_kick = (i == 20);
            push(SEL_RN, 2'd1, $sformatf("kickexp_rn_t%0d", i));
            if (i == 20) push(SEL_BUSY, 2'd0, "kickexp_busy");
            tick();
        end
        wdt_kick = 1'b0;
        wdt_en   = 1'b0;
        tick();

        // Reset pulsed low in the middle of a button request.
        btn_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin
                push(SEL_RN, 2'd0, "rstmid_pulse_low");
                push(SEL_CAUSE, 2'b01, "rstmid_cause_btn");
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        push(SEL_RN, 2'd1, "rstmid_rn");
        push(SEL_CAUSE, 2'b00, "rstmid_cause");
        push(SEL_BUSY, 2'd0, "rstmid_busy");
        drain();
        btn_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Activity resumes on the first edge after release.
        wdt_en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            push(SEL_RN, (i < 20) ? 2'd1 : 2'd0, $sformatf("resume_rn_t%0d", i));
            tick();
        end
        wdt_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rst_request.md
RST_REQUEST -- requirements
Module: rst_request

Interface
REQ-001 SIMULATION, 1'b0, selects shortened timers for simulation.
REQ-002 DEBOUNCE_MS, 10000, button debounce window in clk cycles (simulation value 4).
REQ-003 PULSE_CYCLES, 1000, reset-request low width in clk cycles (simulation value 3).
REQ-004 WDT_CYCLES, 50000, watchdog timeout in clk cycles (simulation value 20).
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn_in  input  1  raw, asynchronous, bouncing reset push-button, active-high.
REQ-008 wdt_en  input  1  watchdog enable, synchronous to clk.
REQ-009 wdt_kick  input  1  single-cycle watchdog service strobe.
REQ-010 rst_req_n  output  1  active-low reset request that drives the downstream reset generator's rst_n.
REQ-011 cause  output  2  last request source: 00 none, 01 button, 10 watchdog; held until the next request.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL pass btn_in through a 2-flop synchronizer (btn_sync), reset value 0.
REQ-014 The FSM SHALL have states IDLE, PRESS_DB, ASSERT and RELEASE_DB.
REQ-015 IDLE: rst_req_n=1; if btn_sync=1, go to PRESS_DB with db_cnt=0.
REQ-016 PRESS_DB: db_cnt increments while btn_sync=1; if btn_sync=0, return to IDLE (bounce rejected).
REQ-017 PRESS_DB: when btn_sync has been 1 for DEBOUNCE_MS consecutive cycles, go to ASSERT with cause=01.
REQ-018 rst_req_n SHALL fall on the edge 2+DEBOUNCE_MS cycles after the first edge that samples btn_in=1, provided btn_in stays high.
REQ-019 ASSERT: rst_req_n=0 for exactly PULSE_CYCLES cycles, independent of btn_sync; then go to RELEASE_DB if cause=01, else IDLE.
REQ-020 RELEASE_DB: rst_req_n=1; return to IDLE only after btn_sync=0 for DEBOUNCE_MS consecutive cycles; any 1 restarts the count.
REQ-021 Consequence of REQ-020: a held button SHALL produce exactly one request.
REQ-022 Watchdog counter wdt_cnt SHALL count only in IDLE with wdt_en=1.
REQ-023 wdt_cnt SHALL clear on wdt_kick, on wdt_en=0, and in every non-IDLE state.
REQ-024 When wdt_cnt reaches WDT_CYCLES-1 in IDLE without a kick, go to ASSERT with cause=10.
REQ-025 Simultaneous kick and expiry: the kick wins; no request.
REQ-026 Simultaneous expiry and btn_sync=1 in IDLE: the watchdog wins; cause=10, then IDLE.
REQ-027 Counters SHALL be 16 bits, saturate rather than wrap, and compare for equality against parameters minus 1.
REQ-028 rst_req_n SHALL be a registered output, free of glitches.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state=IDLE, rst_req_n=1, cause=00, busy=0, all counters 0, synchronizer flops 0.
REQ-030 Reset asserted mid-ASSERT SHALL terminate the pulse immediately (rst_req_n=1).
REQ-031 Reset release SHALL be synchronous; FSM activity resumes on the first edge after release.

Structure
REQ-032 A shared package SHALL hold the state encoding, cause codes and the simulation/real timer constants.
REQ-033 The active timer limit SHALL be selected by SIMULATION: TIMER = SIMULATION ? sim : real.
REQ-034 One sub-module, sync_2ff, SHALL implement the synchronizer.
REQ-035 Everything else SHALL live in rst_request.

Verification (all scenarios with SIMULATION=1)
REQ-036 Clean press: btn_in high for 20 cycles -> rst_req_n low for exactly 3 cycles starting 6 cycles after the first high sample; cause=01; single pulse.
REQ-037 Bounce: btn_in high 3 cycles, low 1, repeated 5 times -> rst_req_n stays 1; FSM returns to IDLE.
REQ-038 Watchdog: wdt_en=1, no kick -> rst_req_n low 3 cycles after 20 idle cycles; cause=10; kick every 10 cycles -> never asserts.
REQ-039 Kick on the expiry cycle -> no request; wdt_cnt returns to 0.
REQ-040 rst_n pulsed low during ASSERT -> rst_req_n=1 immediately; cause=00; state IDLE.
REQ-041 Button held 50 cycles, then released -> one pulse; busy=1 until 4 cycles after btn_sync falls.
